// File: rtl/pipelined_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_controller
// Purpose  : Instruction control path for the pipelined MIPS core. Decodes
//            the instruction at ID into a control word, carries it through
//            registered EX/MEM/WB control stages, stalls the front end on
//            load-use, RAW and multi-cycle mult/div hazards, and discards the
//            ID instruction on a branch/jump flush from EX.
// Ports    : clk, reset (sync, active high)
//            instr_valid, instruction, flush       -> ID inputs
//            instr_ready                           -> ID consumed (= !stall)
//            ex_ALUop, ex_use_imm, ex_jump_register -> EX controls
//            mem_load, mem_store                   -> MEM controls
//            wb_reg_write, wb_dest                 -> WB controls
//            muldiv_busy                           -> mult/div occupies EX
//            ex_fwd_a_sel, ex_fwd_b_sel            -> forwarding selects
//                                                     (PIPE_CTRL_FORWARD_EN)
// Config   : PIPE_CTRL_FORWARD_EN - when defined, EX operands are forwarded
//            from MEM/WB and only load-use and mult/div stall; otherwise any
//            source matching a pending write in EX or MEM stalls.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_controller #(
    parameter int ALUOP_W    = 7,
    parameter int REG_ADDR_W = 5,
    parameter int MULDIV_LAT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [31:0]           instruction,
    input  logic                  flush,
    output logic                  instr_ready,
    output logic [ALUOP_W-1:0]    ex_ALUop,
    output logic                  ex_use_imm,
    output logic                  ex_jump_register,
    output logic                  mem_load,
    output logic                  mem_store,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  muldiv_busy
`ifdef PIPE_CTRL_FORWARD_EN
    ,
    output logic [1:0]            ex_fwd_a_sel,
    output logic [1:0]            ex_fwd_b_sel
`endif
);

    typedef struct packed {
        logic [ALUOP_W-1:0]    alu_op;
        logic                  use_imm;
        logic                  jump_register;
        logic                  mem_load;
        logic                  mem_store;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] dest;
    } ctrl_t;

    localparam ctrl_t    c_bubble   = '0;
    localparam logic [3:0] c_md_load = 4'(MULDIV_LAT - 1);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]            w_opcode;
    logic [5:0]            w_funct;
    logic [REG_ADDR_W-1:0] w_rs;
    logic [REG_ADDR_W-1:0] w_rt;
    logic [REG_ADDR_W-1:0] w_rd;
    logic                  w_unused_shamt;

    assign w_opcode       = instruction[31:26];
    assign w_funct        = instruction[5:0];
    assign w_rs           = REG_ADDR_W'(instruction[25:21]);
    assign w_rt           = REG_ADDR_W'(instruction[20:16]);
    assign w_rd           = REG_ADDR_W'(instruction[15:11]);
    assign w_unused_shamt = ^instruction[10:6];

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    ctrl_t w_dec;
    logic  w_is_muldiv;

    always_comb begin
        w_dec       = c_bubble;
        w_is_muldiv = 1'b0;
        if (w_opcode == 6'd0) begin
            if (w_funct == 6'd8) begin
                w_dec.jump_register = 1'b1;
                w_dec.alu_op        = ALUOP_W'(8);
            end else if (!(w_funct == 6'd0 && w_rd == '0)) begin
                w_dec.alu_op[5:0] = w_funct;
                w_dec.reg_write   = 1'b1;
                w_dec.dest        = w_rd;
                // MULT/MULTU/DIV/DIVU are funct 24..27
                w_is_muldiv       = (w_funct[5:2] == 4'b0110);
            end
        end else begin
            case (w_opcode)
                6'd2, 6'd4, 6'd5: ; // J/BEQ/BNE resolve in EX, no control
                6'd3: begin
                    w_dec.alu_op    = ALUOP_W'(100);
                    w_dec.reg_write = 1'b1;
                    w_dec.dest      = REG_ADDR_W'(31);
                end
                default: begin
                    w_dec.alu_op[ALUOP_W-1] = 1'b1;
                    w_dec.alu_op[5:0]       = w_opcode;
                    w_dec.use_imm           = 1'b1;
                    if (w_opcode == 6'd43) begin
                        w_dec.mem_store = 1'b1;
                    end else begin
                        w_dec.reg_write = 1'b1;
                        w_dec.dest      = w_rt;
                        w_dec.mem_load  = (w_opcode == 6'd35);
                    end
                end
            endcase
        end
        // r0 is hardwired; a write to it is a no-op
        if (w_dec.dest == '0) begin
            w_dec.reg_write = 1'b0;
        end
    end

    // Source usage: rs by all but J/JAL, rt by R-type, SW, BEQ, BNE
    logic w_uses_rs;
    logic w_uses_rt;
    assign w_uses_rs = !(w_opcode == 6'd2 || w_opcode == 6'd3) && (w_rs != '0);
    assign w_uses_rt = (w_opcode == 6'd0 || w_opcode == 6'd43 ||
                        w_opcode == 6'd4 || w_opcode == 6'd5) && (w_rt != '0);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    ctrl_t                 r_ex;
    logic                  r_mem_load;
    logic                  r_mem_store;
    logic                  r_mem_reg_write;
    logic [REG_ADDR_W-1:0] r_mem_dest;
    logic                  r_wb_reg_write;
    logic [REG_ADDR_W-1:0] r_wb_dest;
    logic [3:0]            r_md_cnt;
    logic                  r_flush_pend;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic w_busy;
    logic w_flush;
    logic w_hit_ex;
    logic w_load_use;
    logic w_hazard;
    logic w_stall;
    logic w_take;

    assign w_busy     = (r_md_cnt != 4'd0);
    // A flush arriving during mult/div is remembered and applied once EX frees
    assign w_flush    = (flush || r_flush_pend) && !w_busy;
    assign w_hit_ex   = (w_uses_rs && w_rs == r_ex.dest) ||
                        (w_uses_rt && w_rt == r_ex.dest);
    assign w_load_use = r_ex.mem_load && w_hit_ex;

`ifdef PIPE_CTRL_FORWARD_EN
    assign w_hazard = w_load_use;

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;

    // Computed against the current EX/MEM, which become MEM/WB once this
    // instruction is in EX; MEM wins a double match as the younger result.
    always_comb begin
        w_fwd_a = 2'd0;
        w_fwd_b = 2'd0;
        if (w_uses_rs && r_ex.reg_write && w_rs == r_ex.dest) begin
            w_fwd_a = 2'd1;
        end else if (w_uses_rs && r_mem_reg_write && w_rs == r_mem_dest) begin
            w_fwd_a = 2'd2;
        end
        if (w_uses_rt && r_ex.reg_write && w_rt == r_ex.dest) begin
            w_fwd_b = 2'd1;
        end else if (w_uses_rt && r_mem_reg_write && w_rt == r_mem_dest) begin
            w_fwd_b = 2'd2;
        end
    end

    assign ex_fwd_a_sel = r_fwd_a;
    assign ex_fwd_b_sel = r_fwd_b;
`else
    logic w_hit_mem;
    assign w_hit_mem = (w_uses_rs && w_rs == r_mem_dest) ||
                       (w_uses_rt && w_rt == r_mem_dest);
    // WB needs no check: the regfile writes before it is read
    assign w_hazard  = w_load_use || (r_ex.reg_write && w_hit_ex) ||
                       (r_mem_reg_write && w_hit_mem);
`endif

    assign w_stall = w_busy || (instr_valid && !w_flush && w_hazard);
    assign w_take  = instr_valid && !w_stall && !w_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex            <= c_bubble;
            r_mem_load      <= 1'b0;
            r_mem_store     <= 1'b0;
            r_mem_reg_write <= 1'b0;
            r_mem_dest      <= '0;
            r_wb_reg_write  <= 1'b0;
            r_wb_dest       <= '0;
            r_md_cnt        <= 4'd0;
            r_flush_pend    <= 1'b0;
`ifdef PIPE_CTRL_FORWARD_EN
            r_fwd_a         <= 2'd0;
            r_fwd_b         <= 2'd0;
`endif
        end else begin
            r_wb_reg_write <= r_mem_reg_write;
            r_wb_dest      <= r_mem_dest;
            if (w_busy) begin
                // EX holds the mult/div; MEM fills with bubbles
                r_mem_load      <= 1'b0;
                r_mem_store     <= 1'b0;
                r_mem_reg_write <= 1'b0;
                r_mem_dest      <= '0;
                r_md_cnt        <= r_md_cnt - 4'd1;
                r_flush_pend    <= r_flush_pend || flush;
            end else begin
                r_mem_load      <= r_ex.mem_load;
                r_mem_store     <= r_ex.mem_store;
                r_mem_reg_write <= r_ex.reg_write;
                r_mem_dest      <= r_ex.dest;
                r_ex            <= w_take ? w_dec : c_bubble;
                r_md_cnt        <= (w_take && w_is_muldiv) ? c_md_load : 4'd0;
                r_flush_pend    <= 1'b0;
`ifdef PIPE_CTRL_FORWARD_EN
                r_fwd_a         <= w_take ? w_fwd_a : 2'd0;
                r_fwd_b         <= w_take ? w_fwd_b : 2'd0;
`endif
            end
        end
    end

    assign instr_ready      = !w_stall;
    assign ex_ALUop         = r_ex.alu_op;
    assign ex_use_imm       = r_ex.use_imm;
    assign ex_jump_register = r_ex.jump_register;
    assign mem_load         = r_mem_load;
    assign mem_store        = r_mem_store;
    assign wb_reg_write     = r_wb_reg_write;
    assign wb_dest          = r_wb_dest;
    assign muldiv_busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_controller
// Purpose  : Directed self-checking bench for pipelined_controller with
//            hand-computed expectations (MULDIV_LAT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_controller;

    localparam logic [31:0] c_add3  = 32'h00221820; // ADD r3,r1,r2
    localparam logic [31:0] c_lw4   = 32'h8C240000; // LW  r4,0(r1)
    localparam logic [31:0] c_add5  = 32'h00822820; // ADD r5,r4,r2
    localparam logic [31:0] c_add7  = 32'h00223820; // ADD r7,r1,r2
    localparam logic [31:0] c_mult  = 32'h00220018; // MULT r1,r2
    localparam logic [31:0] c_sw    = 32'hAC240000; // SW  r4,0(r1)
    localparam logic [31:0] c_beq   = 32'h10220000; // BEQ r1,r2,0
    localparam logic [31:0] c_nop   = 32'h00000000;
    localparam logic [31:0] c_add0  = 32'h00220020; // ADD r0,r1,r2
    localparam logic [31:0] c_jal   = 32'h0C000000; // JAL 0
    localparam logic [31:0] c_jr    = 32'h03E00008; // JR r31
    localparam logic [31:0] c_sub6  = 32'h00633022; // SUB r6,r3,r3

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        flush;
    logic        instr_ready;
    logic [6:0]  ex_ALUop;
    logic        ex_use_imm;
    logic        ex_jump_register;
    logic        mem_load;
    logic        mem_store;
    logic        wb_reg_write;
    logic [4:0]  wb_dest;
    logic        muldiv_busy;
`ifdef PIPE_CTRL_FORWARD_EN
    logic [1:0]  ex_fwd_a_sel;
    logic [1:0]  ex_fwd_b_sel;
`endif

    int n_vec = 0;
    int n_err = 0;

    pipelined_controller #(
        .ALUOP_W   (7),
        .REG_ADDR_W(5),
        .MULDIV_LAT(4)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .instr_valid     (instr_valid),
        .instruction     (instruction),
        .flush           (flush),
        .instr_ready     (instr_ready),
        .ex_ALUop        (ex_ALUop),
        .ex_use_imm      (ex_use_imm),
        .ex_jump_register(ex_jump_register),
        .mem_load        (mem_load),
        .mem_store       (mem_store),
        .wb_reg_write    (wb_reg_write),
        .wb_dest         (wb_dest),
        .muldiv_busy     (muldiv_busy)
`ifdef PIPE_CTRL_FORWARD_EN
        ,
        .ex_fwd_a_sel    (ex_fwd_a_sel),
        .ex_fwd_b_sel    (ex_fwd_b_sel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
        instr_valid = v;
        instruction = ins;
        flush       = fl;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, c_nop, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(1'b0, c_nop, 1'b0);
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check_eq("rst_ready", 32'(instr_ready), 32'd1);
        check_eq("rst_alu", 32'(ex_ALUop), 32'd0);
        check_eq("rst_busy", 32'(muldiv_busy), 32'd0);
        check_eq("rst_wb", 32'(wb_reg_write), 32'd0);
        check_eq("rst_memld", 32'(mem_load), 32'd0);

        // ADD r3,r1,r2 latency
        drive(1'b1, c_add3, 1'b0);
        check_eq("add_ready", 32'(instr_ready), 32'd1);
        tick();
        check_eq("add_ex_alu", 32'(ex_ALUop), 32'h20);
        check_eq("add_ex_imm", 32'(ex_use_imm), 32'd0);
        drive(1'b0, c_nop, 1'b0);
        tick();
        tick();
        check_eq("add_wb_we", 32'(wb_reg_write), 32'd1);
        check_eq("add_wb_dest", 32'(wb_dest), 32'd3);
        idle(3);

        // LW r4 then ADD r5,r4,r2: load-use
        drive(1'b1, c_lw4, 1'b0);
        tick();
        check_eq("lw_ex_alu", 32'(ex_ALUop), 32'h63);
        check_eq("lw_ex_imm", 32'(ex_use_imm), 32'd1);
        drive(1'b1, c_add5, 1'b0);
        check_eq("lu_stall", 32'(instr_ready), 32'd0);
        tick();
        check_eq("lu_bubble", 32'(ex_ALUop), 32'd0);
        check_eq("lu_mem_load", 32'(mem_load), 32'd1);
`ifdef PIPE_CTRL_FORWARD_EN
        check_eq("lu_release", 32'(instr_ready), 32'd1);
        tick();
        check_eq("lu_fwd_a", 32'(ex_fwd_a_sel), 32'd2);
        check_eq("lu_fwd_b", 32'(ex_fwd_b_sel), 32'd0);
        check_eq("lu_lw_wb", 32'(wb_dest), 32'd4);
`else
        // Without forwarding the LW now in MEM still blocks the ADD
        check_eq("raw_mem_stall", 32'(instr_ready), 32'd0);
        tick();
        check_eq("raw_mem_bubble", 32'(ex_ALUop), 32'd0);
        check_eq("lu_release", 32'(instr_ready), 32'd1);
        tick();
`endif
        check_eq("lu_add_ex", 32'(ex_ALUop), 32'h20);
        drive(1'b0, c_nop, 1'b0);
        tick();
        tick();
        check_eq("lu_add_wb_we", 32'(wb_reg_write), 32'd1);
        check_eq("lu_add_wb_dest", 32'(wb_dest), 32'd5);
        idle(3);

        // MULT occupies EX for 4 cycles
        drive(1'b1, c_mult, 1'b0);
        tick();
        check_eq("md_busy", 32'(muldiv_busy), 32'd1);
        check_eq("md_ex_alu", 32'(ex_ALUop), 32'h18);
        drive(1'b1, c_add7, 1'b0);
        n = 0;
        while (muldiv_busy && n < 20) begin
            check_eq("md_ready_low", 32'(instr_ready), 32'd0);
            check_eq("md_ex_hold", 32'(ex_ALUop), 32'h18);
            n++;
            tick();
        end
        check_eq("md_busy_cycles", 32'(n), 32'd3);
        check_eq("md_release", 32'(instr_ready), 32'd1);
        tick();
        check_eq("md_next_ex", 32'(ex_ALUop), 32'h20);
        idle(4);

        // Flush during MULT is held until the mult/div frees EX
        drive(1'b1, c_mult, 1'b0);
        tick();
        drive(1'b1, c_add7, 1'b1);
        check_eq("mdfl_ready", 32'(instr_ready), 32'd0);
        tick();
        drive(1'b1, c_add7, 1'b0);
        n = 0;
        while (muldiv_busy && n < 20) begin
            n++;
            tick();
        end
        check_eq("mdfl_cycles", 32'(n), 32'd2);
        check_eq("mdfl_ready_after", 32'(instr_ready), 32'd1);
        tick();
        check_eq("mdfl_bubble", 32'(ex_ALUop), 32'd0);
        drive(1'b0, c_nop, 1'b0);
        tick();
        tick();
        check_eq("mdfl_no_wb", 32'(wb_reg_write), 32'd0);
        idle(3);

        // Flush during load-use stall
        drive(1'b1, c_lw4, 1'b0);
        tick();
        drive(1'b1, c_add5, 1'b1);
        check_eq("flush_ready", 32'(instr_ready), 32'd1);
        tick();
        check_eq("flush_bubble", 32'(ex_ALUop), 32'd0);
        drive(1'b0, c_nop, 1'b0);
        tick();
        check_eq("flush_lw_wb_we", 32'(wb_reg_write), 32'd1);
        check_eq("flush_lw_wb_dest", 32'(wb_dest), 32'd4);
        tick();
        check_eq("flush_no_wb", 32'(wb_reg_write), 32'd0);
        idle(3);

        // SW, BEQ, nop, ADD r0, JAL back to back
        drive(1'b1, c_sw, 1'b0);
        check_eq("sw_ready", 32'(instr_ready), 32'd1);
        tick();
        check_eq("sw_ex_alu", 32'(ex_ALUop), 32'h6B);
        check_eq("sw_ex_imm", 32'(ex_use_imm), 32'd1);
        drive(1'b1, c_beq, 1'b0);
        tick();
        check_eq("beq_bubble", 32'(ex_ALUop), 32'd0);
        check_eq("sw_mem_store", 32'(mem_store), 32'd1);
        drive(1'b1, c_nop, 1'b0);
        tick();
        check_eq("beq_mem_store", 32'(mem_store), 32'd0);
        check_eq("sw_no_wb", 32'(wb_reg_write), 32'd0);
        drive(1'b1, c_add0, 1'b0);
        tick();
        check_eq("add0_ex_alu", 32'(ex_ALUop), 32'h20);
        check_eq("beq_no_wb", 32'(wb_reg_write), 32'd0);
        drive(1'b1, c_jal, 1'b0);
        tick();
        check_eq("jal_ex_alu", 32'(ex_ALUop), 32'd100);
        check_eq("jal_ex_imm", 32'(ex_use_imm), 32'd0);
        check_eq("nop_no_wb", 32'(wb_reg_write), 32'd0);
        drive(1'b0, c_nop, 1'b0);
        tick();
        check_eq("add0_no_wb", 32'(wb_reg_write), 32'd0);
        tick();
        check_eq("jal_wb_we", 32'(wb_reg_write), 32'd1);
        check_eq("jal_wb_dest", 32'(wb_dest), 32'd31);

        // JR
        drive(1'b1, c_jr, 1'b0);
        tick();
        check_eq("jr_ex_jr", 32'(ex_jump_register), 32'd1);
        check_eq("jr_ex_alu", 32'(ex_ALUop), 32'd8);
        idle(4);

        // ADD r3 then SUB r6,r3,r3
        drive(1'b1, c_add3, 1'b0);
        tick();
        drive(1'b0, c_sub6, 1'b0);
        check_eq("invalid_no_hazard", 32'(instr_ready), 32'd1);
        drive(1'b1, c_sub6, 1'b0);
`ifdef PIPE_CTRL_FORWARD_EN
        check_eq("sub_no_stall", 32'(instr_ready), 32'd1);
        tick();
        check_eq("sub_fwd_a", 32'(ex_fwd_a_sel), 32'd1);
        check_eq("sub_fwd_b", 32'(ex_fwd_b_sel), 32'd1);
`else
        n = 0;
        while (!instr_ready && n < 10) begin
            n++;
            tick();
        end
        check_eq("sub_stall_cycles", 32'(n), 32'd2);
        tick();
`endif
        check_eq("sub_ex_alu", 32'(ex_ALUop), 32'h22);
        idle(4);

        // Reset mid-muldiv aborts immediately
        drive(1'b1, c_mult, 1'b0);
        tick();
        check_eq("rmd_busy", 32'(muldiv_busy), 32'd1);
        drive(1'b0, c_nop, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rmd_busy_clr", 32'(muldiv_busy), 32'd0);
        check_eq("rmd_ready", 32'(instr_ready), 32'd1);
        check_eq("rmd_ex_alu", 32'(ex_ALUop), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
